// File: rtl/pixel_stream_sequencer.sv
// Walks one frame of image-buffer / weights-ROM addresses, realigns the returned pixels with the
// ROM read latency and sequences the downstream multiply-accumulate lanes up to the result pulse.
module pixel_stream_sequencer #(
   parameter int GRAY_WIDTH      = 8,
   parameter int PIXEL_WIDTH     = 16,
   parameter int PIXEL_COUNT     = 784,
   parameter int INDEX_WIDTH     = 10,
   parameter int ROM_LATENCY     = 1,
   parameter int MAC_LATENCY     = 2,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic                       pclk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [GRAY_WIDTH-1:0]      img_rdata,
   output logic [INDEX_WIDTH-1:0]     pixel_index,
   output logic [PIXEL_WIDTH-1:0]     pixel_data,
   output logic                       pixel_valid,
   output logic                       accum_sload,
   output logic                       busy,
   output logic                       result_valid,
   output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

   localparam int DRAIN_CYCLES = ROM_LATENCY + MAC_LATENCY;
   localparam int DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(PIXEL_COUNT - 1);
   localparam logic [DRAIN_W-1:0]     DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t                     state_q;
   logic [INDEX_WIDTH-1:0]     index_q;
   logic [DRAIN_W-1:0]         drain_q;
   logic                       busy_q;
   logic                       result_valid_q;
   logic [FRAME_CNT_WIDTH-1:0] frame_count_q;
   logic [ROM_LATENCY-1:0]     valid_sr_q, valid_sr_d;
   logic [ROM_LATENCY-1:0]     sload_sr_q, sload_sr_d;
   logic                       issue_flag;
   logic                       first_flag;
   logic                       abort_hit;

   assign issue_flag = (state_q == ISSUE);
   assign first_flag = issue_flag && (index_q == '0);
   assign abort_hit  = abort && (state_q != IDLE);

   // The ROM returns data ROM_LATENCY cycles after the address, so the issue flags ride a matching
   // shift register; an abort empties it so no in-flight pixel reaches the accumulators.
   always_comb begin
      valid_sr_d = ROM_LATENCY'({valid_sr_q, issue_flag});
      sload_sr_d = ROM_LATENCY'({sload_sr_q, first_flag});
      if (abort_hit) begin
         valid_sr_d = '0;
         sload_sr_d = '0;
      end
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         valid_sr_q <= '0;
         sload_sr_q <= '0;
      end else begin
         valid_sr_q <= valid_sr_d;
         sload_sr_q <= sload_sr_d;
      end
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         index_q        <= '0;
         drain_q        <= '0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         frame_count_q  <= '0;
      end else begin
         result_valid_q <= 1'b0;
         if (abort_hit) begin
            state_q <= IDLE;
            index_q <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  index_q <= '0;
                  if (start && !abort) begin
                     state_q <= ISSUE;
                     busy_q  <= 1'b1;
                  end
               end
               ISSUE: begin
                  if (index_q == LAST_INDEX) begin
                     state_q <= DRAIN;
                     index_q <= '0;
                     drain_q <= '0;
                  end else begin
                     index_q <= index_q + INDEX_WIDTH'(1);
                  end
               end
               DRAIN: begin
                  // Hold off the result until the last pixel has passed the ROM and the MAC pipeline.
                  if (drain_q == DRAIN_LAST) begin
                     state_q        <= DONE;
                     busy_q         <= 1'b0;
                     result_valid_q <= 1'b1;
                     frame_count_q  <= frame_count_q + FRAME_CNT_WIDTH'(1);
                  end else begin
                     drain_q <= drain_q + DRAIN_W'(1);
                  end
               end
               DONE: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign pixel_index  = index_q;
   assign pixel_valid  = valid_sr_q[ROM_LATENCY-1];
   assign accum_sload  = sload_sr_q[ROM_LATENCY-1];
   assign pixel_data   = pixel_valid ? PIXEL_WIDTH'(img_rdata) : '0;
   assign busy         = busy_q;
   assign result_valid = result_valid_q;
   assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// Scoreboard bench: a default-size sequencer and a small PIXEL_COUNT=4 / ROM_LATENCY=2 instance.
module tb_pixel_stream_sequencer;

   logic pclk  = 1'b0;
   logic rst_n = 1'b0;
   always #5 pclk = ~pclk;

   int cyc  = 0;
   int vecs = 0;
   int errs = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   logic        a_start = 1'b0, a_abort = 1'b0;
   logic [7:0]  a_rd;
   logic [9:0]  a_idx;
   logic [15:0] a_pdata;
   logic        a_pv, a_sl, a_busy, a_rv;
   logic [15:0] a_fc;

   logic        b_start = 1'b0, b_abort = 1'b0;
   logic [7:0]  b_rd, b_rd1;
   logic [1:0]  b_idx;
   logic [15:0] b_pdata;
   logic        b_pv, b_sl, b_busy, b_rv;
   logic [1:0]  b_fc;

   pixel_stream_sequencer u_a (
      .pclk(pclk), .rst(rst_n), .start(a_start), .abort(a_abort), .img_rdata(a_rd),
      .pixel_index(a_idx), .pixel_data(a_pdata), .pixel_valid(a_pv), .accum_sload(a_sl),
      .busy(a_busy), .result_valid(a_rv), .frame_count(a_fc)
   );

   pixel_stream_sequencer #(
      .PIXEL_COUNT(4), .INDEX_WIDTH(2), .ROM_LATENCY(2), .FRAME_CNT_WIDTH(2)
   ) u_b (
      .pclk(pclk), .rst(rst_n), .start(b_start), .abort(b_abort), .img_rdata(b_rd),
      .pixel_index(b_idx), .pixel_data(b_pdata), .pixel_valid(b_pv), .accum_sload(b_sl),
      .busy(b_busy), .result_valid(b_rv), .frame_count(b_fc)
   );

   // Image buffer models: one-cycle read returning the low address byte, two-cycle read returning A0+addr.
   always @(posedge pclk) a_rd <= a_idx[7:0];
   always @(posedge pclk) begin
      b_rd1 <= 8'hA0 | {6'd0, b_idx};
      b_rd  <= b_rd1;
   end

   typedef struct {
      int          cyc;
      logic [15:0] data;
      logic        sload;
   } pix_t;

   pix_t a_pix_q[$];
   pix_t b_pix_q[$];
   int   a_rv_q[$];
   int   b_rv_q[$];
   pix_t a_p, b_p;
   int   a_r, b_r;

   always @(negedge pclk) begin
      if (rst_n) begin
         vecs++;
         if (a_pv) begin
            if (a_pix_q.size() == 0) begin
               errs++;
               $display("FAIL a_pixel_unexpected: cyc=%0d data=%0h sload=%b, required no valid pixel", cyc, a_pdata, a_sl);
            end else begin
               a_p = a_pix_q.pop_front();
               if (cyc !== a_p.cyc || a_pdata !== a_p.data || a_sl !== a_p.sload) begin
                  errs++;
                  $display("FAIL a_pixel: cyc=%0d data=%0h sload=%b, required cyc=%0d data=%0h sload=%b",
                           cyc, a_pdata, a_sl, a_p.cyc, a_p.data, a_p.sload);
               end
            end
         end else if (a_pdata !== 16'd0 || a_sl !== 1'b0) begin
            errs++;
            $display("FAIL a_gate: cyc=%0d data=%0h sload=%b without pixel_valid, required 0/0", cyc, a_pdata, a_sl);
         end
         vecs++;
         if (b_pv) begin
            if (b_pix_q.size() == 0) begin
               errs++;
               $display("FAIL b_pixel_unexpected: cyc=%0d data=%0h sload=%b, required no valid pixel", cyc, b_pdata, b_sl);
            end else begin
               b_p = b_pix_q.pop_front();
               if (cyc !== b_p.cyc || b_pdata !== b_p.data || b_sl !== b_p.sload) begin
                  errs++;
                  $display("FAIL b_pixel: cyc=%0d data=%0h sload=%b, required cyc=%0d data=%0h sload=%b",
                           cyc, b_pdata, b_sl, b_p.cyc, b_p.data, b_p.sload);
               end
            end
         end else if (b_pdata !== 16'd0 || b_sl !== 1'b0) begin
            errs++;
            $display("FAIL b_gate: cyc=%0d data=%0h sload=%b without pixel_valid, required 0/0", cyc, b_pdata, b_sl);
         end
         if (a_rv) begin
            vecs++;
            if (a_rv_q.size() == 0) begin
               errs++;
               $display("FAIL a_result_unexpected: result_valid at cyc=%0d, required none", cyc);
            end else begin
               a_r = a_rv_q.pop_front();
               if (cyc !== a_r) begin
                  errs++;
                  $display("FAIL a_result_time: result_valid at cyc=%0d, required cyc=%0d", cyc, a_r);
               end
            end
         end
         if (b_rv) begin
            vecs++;
            if (b_rv_q.size() == 0) begin
               errs++;
               $display("FAIL b_result_unexpected: result_valid at cyc=%0d, required none", cyc);
            end else begin
               b_r = b_rv_q.pop_front();
               if (cyc !== b_r) begin
                  errs++;
                  $display("FAIL b_result_time: result_valid at cyc=%0d, required cyc=%0d", cyc, b_r);
               end
            end
         end
      end
   end

   // e is the counter value right after the edge that samples start.
   task automatic push_a_frame(input int e);
      pix_t p;
      for (int k = 0; k < 784; k++) begin
         p.cyc   = e + k + 1;
         p.data  = 16'(k & 255);
         p.sload = (k == 0);
         a_pix_q.push_back(p);
      end
      a_rv_q.push_back(e + 787);
   endtask

   task automatic push_b_frame(input int e);
      pix_t p;
      for (int k = 0; k < 4; k++) begin
         p.cyc   = e + k + 2;
         p.data  = 16'h00A0 + 16'(k);
         p.sload = (k == 0);
         b_pix_q.push_back(p);
      end
      b_rv_q.push_back(e + 8);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      a_pix_q.delete(); a_rv_q.delete(); b_pix_q.delete(); b_rv_q.delete();
      repeat (2) @(posedge pclk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      vecs++;
      if ({a_idx, a_pdata, a_pv, a_sl, a_busy, a_rv, a_fc} !== 46'd0) begin
         errs++;
         $display("FAIL reset_a_outputs: idx=%0d data=%0h pv=%b sl=%b busy=%b rv=%b fc=%0d, required all 0",
                  a_idx, a_pdata, a_pv, a_sl, a_busy, a_rv, a_fc);
      end
      vecs++;
      if ({b_idx, b_pdata, b_pv, b_sl, b_busy, b_rv, b_fc} !== 24'd0) begin
         errs++;
         $display("FAIL reset_b_outputs: idx=%0d data=%0h pv=%b sl=%b busy=%b rv=%b fc=%0d, required all 0",
                  b_idx, b_pdata, b_pv, b_sl, b_busy, b_rv, b_fc);
      end
      rst_n = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(posedge pclk); #1;
         vecs++;
         if ({a_idx, a_pdata, a_pv, a_sl, a_busy, a_rv, a_fc} !== 46'd0) begin
            errs++;
            $display("FAIL post_reset_a: cycle %0d busy=%b pv=%b idx=%0d fc=%0d, required all 0", n, a_busy, a_pv, a_idx, a_fc);
         end
         vecs++;
         if ({b_idx, b_pdata, b_pv, b_sl, b_busy, b_rv, b_fc} !== 24'd0) begin
            errs++;
            $display("FAIL post_reset_b: cycle %0d busy=%b pv=%b idx=%0d fc=%0d, required all 0", n, b_busy, b_pv, b_idx, b_fc);
         end
      end
   endtask

   task automatic test_single_frame();
      int          e;
      logic [15:0] fc0;
      logic [9:0]  exp_idx;
      logic        exp_busy;
      @(posedge pclk); #1;
      fc0 = a_fc;
      e   = cyc + 1;
      push_a_frame(e);
      a_start = 1'b1;
      @(posedge pclk); #1;
      a_start = 1'b0;
      for (int n = 1; n <= 792; n++) begin
         exp_idx  = (n <= 784) ? 10'(n - 1) : 10'd0;
         exp_busy = (n <= 787);
         vecs++;
         if (a_idx !== exp_idx || a_busy !== exp_busy) begin
            errs++;
            $display("FAIL frame_seq: rel cycle %0d idx=%0d busy=%b, required idx=%0d busy=%b", n, a_idx, a_busy, exp_idx, exp_busy);
         end
         @(posedge pclk); #1;
      end
      vecs++;
      if (a_pix_q.size() != 0 || a_rv_q.size() != 0) begin
         errs++;
         $display("FAIL frame_missing: %0d pixels and %0d results outstanding, required 0/0", a_pix_q.size(), a_rv_q.size());
      end
      vecs++;
      if (a_fc !== fc0 + 16'd1) begin
         errs++;
         $display("FAIL frame_count: got %0d, required %0d", a_fc, fc0 + 16'd1);
      end
   endtask

   task automatic test_start_ignored();
      int e;
      do_reset();
      @(posedge pclk); #1;
      e = cyc + 1;
      push_a_frame(e);
      for (int n = 0; n <= 1590; n++) begin
         a_start = (n == 0 || n == 300 || n == 787 || n == 790);
         if (n == 790) push_a_frame(e + 790);
         @(posedge pclk); #1;
      end
      a_start = 1'b0;
      vecs++;
      if (a_pix_q.size() != 0 || a_rv_q.size() != 0) begin
         errs++;
         $display("FAIL start_ignored_missing: %0d pixels and %0d results outstanding, required 0/0", a_pix_q.size(), a_rv_q.size());
      end
      vecs++;
      if (a_fc !== 16'd2) begin
         errs++;
         $display("FAIL start_ignored_count: got %0d, required 2", a_fc);
      end
   endtask

   task automatic test_abort();
      int          e;
      int          waited;
      logic [15:0] fc0;
      @(posedge pclk); #1;
      fc0 = a_fc;
      e   = cyc + 1;
      push_a_frame(e);
      a_start = 1'b1;
      @(posedge pclk); #1;
      a_start = 1'b0;
      waited = 0;
      while (a_idx !== 10'd100 && waited < 200) begin
         @(posedge pclk); #1;
         waited++;
      end
      vecs++;
      if (a_idx !== 10'd100) begin
         errs++;
         $display("FAIL abort_reach: idx=%0d after %0d cycles, required 100", a_idx, waited);
      end
      a_abort = 1'b1;
      @(posedge pclk); #1;
      a_abort = 1'b0;
      vecs++;
      if (a_busy !== 1'b0 || a_pv !== 1'b0 || a_sl !== 1'b0 || a_idx !== 10'd0) begin
         errs++;
         $display("FAIL abort_next: busy=%b pv=%b sl=%b idx=%0d, required 0/0/0/0", a_busy, a_pv, a_sl, a_idx);
      end
      a_pix_q.delete();
      a_rv_q.delete();
      repeat (1000) @(posedge pclk);
      #1;
      vecs++;
      if (a_fc !== fc0 || a_busy !== 1'b0) begin
         errs++;
         $display("FAIL abort_count: fc=%0d busy=%b, required fc=%0d busy=0", a_fc, a_busy, fc0);
      end
      test_single_frame();
   endtask

   task automatic test_async_reset();
      int waited;
      @(posedge pclk); #1;
      push_a_frame(cyc + 1);
      a_start = 1'b1;
      @(posedge pclk); #1;
      a_start = 1'b0;
      waited = 0;
      while (a_idx !== 10'd400 && waited < 500) begin
         @(posedge pclk); #1;
         waited++;
      end
      vecs++;
      if (a_idx !== 10'd400) begin
         errs++;
         $display("FAIL async_reach: idx=%0d, required 400", a_idx);
      end
      #2 rst_n = 1'b0;
      #1;
      vecs++;
      if ({a_idx, a_pdata, a_pv, a_sl, a_busy, a_rv, a_fc} !== 46'd0) begin
         errs++;
         $display("FAIL async_reset: idx=%0d data=%0h pv=%b sl=%b busy=%b fc=%0d before edge, required all 0",
                  a_idx, a_pdata, a_pv, a_sl, a_busy, a_fc);
      end
      a_pix_q.delete();
      a_rv_q.delete();
      @(posedge pclk); #1;
      rst_n = 1'b1;
      test_single_frame();
   endtask

   task automatic test_small_config();
      int         e;
      logic [1:0] exp_idx;
      logic       exp_busy;
      logic [1:0] exp_fc;
      logic [1:0] fc0;
      do_reset();
      @(posedge pclk); #1;
      for (int f = 0; f < 5; f++) begin
         e = cyc + 1;
         push_b_frame(e);
         b_start = 1'b1;
         @(posedge pclk); #1;
         b_start = 1'b0;
         for (int n = 1; n <= 10; n++) begin
            exp_idx  = (n <= 4) ? 2'(n - 1) : 2'd0;
            exp_busy = (n <= 8);
            vecs++;
            if (b_idx !== exp_idx || b_busy !== exp_busy) begin
               errs++;
               $display("FAIL small_seq: frame %0d rel cycle %0d idx=%0d busy=%b, required idx=%0d busy=%b",
                        f, n, b_idx, b_busy, exp_idx, exp_busy);
            end
            @(posedge pclk); #1;
         end
         exp_fc = 2'(f + 1);
         vecs++;
         if (b_fc !== exp_fc || b_pix_q.size() != 0 || b_rv_q.size() != 0) begin
            errs++;
            $display("FAIL small_frame: frame %0d fc=%0d outstanding=%0d/%0d, required fc=%0d outstanding=0/0",
                     f, b_fc, b_pix_q.size(), b_rv_q.size(), exp_fc);
         end
      end
      fc0 = b_fc;
      b_start = 1'b1;
      b_abort = 1'b1;
      @(posedge pclk); #1;
      b_start = 1'b0;
      b_abort = 1'b0;
      for (int n = 0; n < 12; n++) begin
         vecs++;
         if (b_busy !== 1'b0 || b_idx !== 2'd0) begin
            errs++;
            $display("FAIL start_abort_idle: cycle %0d busy=%b idx=%0d, required busy=0 idx=0", n, b_busy, b_idx);
         end
         @(posedge pclk); #1;
      end
      vecs++;
      if (b_fc !== fc0) begin
         errs++;
         $display("FAIL start_abort_count: fc=%0d, required %0d", b_fc, fc0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, required bench completion");
      $fatal(1, "bench did not complete");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_start_ignored();
      test_abort();
      test_async_reset();
      test_small_config();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
